alu_request_arbiter: RTL and testbench

//  Shares one registered 8-bit alu (opcode/input1/input2 -> alu_output) between NUM_REQ requesters.

---
 rtl/alu_request_arbiter.sv | 168 ++++++++++++++++
 tb/tb_alu_request_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_request_arbiter.sv
// alu_request_arbiter: round-robin sharing of one registered alu between requesters.
// Optional build macro ALU_ARB_ILLEGAL_OP_EN: opcodes above 3'b100 are answered with an error.
module alu_request_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 3,
    parameter int ALU_LATENCY  = 1
) (
    input  logic                             clock_in,
    input  logic                             reset_in,
    input  logic [NUM_REQ-1:0]               req_valid_in,
    output logic [NUM_REQ-1:0]               req_ready_out,
    input  logic [NUM_REQ*OPCODE_WIDTH-1:0]  req_opcode_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_input1_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_input2_in,
    output logic [NUM_REQ-1:0]               resp_valid_out,
    input  logic [NUM_REQ-1:0]               resp_ready_in,
    output logic [DATA_WIDTH-1:0]            resp_data_out,
    output logic                             resp_error_out,
    output logic                             alu_enable_out,
    output logic [OPCODE_WIDTH-1:0]          alu_opcode_out,
    output logic [DATA_WIDTH-1:0]            alu_input1_out,
    output logic [DATA_WIDTH-1:0]            alu_input2_out,
    input  logic [DATA_WIDTH-1:0]            alu_result_in,
    output logic                             busy_out
);

    localparam int PW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] WAIT    = 2'd2;
    localparam logic [1:0] RESPOND = 2'd3;

    logic [1:0]              state;
    logic [PW-1:0]           ptr;
    logic [PW-1:0]           owner;
    logic [OPCODE_WIDTH-1:0] op_q;
    logic [DATA_WIDTH-1:0]   in1_q;
    logic [DATA_WIDTH-1:0]   in2_q;
    logic [DATA_WIDTH-1:0]   result_q;
    logic [CW-1:0]           cnt;

    logic                    grant_valid;
    logic [PW-1:0]           grant_idx;
    logic [PW:0]             cand;
    logic [NUM_REQ-1:0]      grant_oh;
    logic [NUM_REQ-1:0]      owner_oh;
    logic [OPCODE_WIDTH-1:0] sel_op;
    logic [DATA_WIDTH-1:0]   sel_a;
    logic [DATA_WIDTH-1:0]   sel_b;
    logic                    accept;
    logic                    illegal;
    logic                    resp_take;
    logic                    alu_active;
    logic [PW-1:0]           ptr_next;

    // Scan downwards so the candidate closest to ptr is the one left standing.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(NUM_REQ))
                cand = cand - (PW+1)'(NUM_REQ);
            if (req_valid_in[cand[PW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        sel_op   = '0;
        sel_a    = '0;
        sel_b    = '0;
        grant_oh = '0;
        owner_oh = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_idx == PW'(k)) begin
                sel_op      = req_opcode_in[k*OPCODE_WIDTH +: OPCODE_WIDTH];
                sel_a       = req_input1_in[k*DATA_WIDTH +: DATA_WIDTH];
                sel_b       = req_input2_in[k*DATA_WIDTH +: DATA_WIDTH];
                grant_oh[k] = 1'b1;
            end
            if (owner == PW'(k))
                owner_oh[k] = 1'b1;
        end
    end

    assign accept     = (state == IDLE) && grant_valid && reset_in;
    assign resp_take  = (state == RESPOND) && |(resp_ready_in & owner_oh);
    assign alu_active = (state == ISSUE) || (state == WAIT);
    assign ptr_next   = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    assign req_ready_out  = accept ? grant_oh : '0;
    assign resp_valid_out = (state == RESPOND) ? owner_oh : '0;
    assign resp_data_out  = (state == RESPOND) ? result_q : '0;
    assign alu_enable_out = alu_active;
    assign alu_opcode_out = alu_active ? op_q : '0;
    assign alu_input1_out = alu_active ? in1_q : '0;
    assign alu_input2_out = alu_active ? in2_q : '0;
    assign busy_out       = (state != IDLE);

`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic err_q;

    assign illegal        = (sel_op > OPCODE_WIDTH'(4));
    assign resp_error_out = (state == RESPOND) && err_q;

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in)
            err_q <= 1'b0;
        else if (accept)
            err_q <= illegal;
    end
`else
    assign illegal        = 1'b0;
    assign resp_error_out = 1'b0;
`endif

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            op_q     <= '0;
            in1_q    <= '0;
            in2_q    <= '0;
            result_q <= '0;
            cnt      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        owner    <= grant_idx;
                        op_q     <= sel_op;
                        in1_q    <= sel_a;
                        in2_q    <= sel_b;
                        result_q <= '0;
                        ptr      <= ptr_next;
                        state    <= illegal ? RESPOND : ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= CW'(ALU_LATENCY - 1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        result_q <= alu_result_in;
                        state    <= RESPOND;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESPOND: begin
                    if (resp_take)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_request_arbiter.sv
// tb_alu_request_arbiter: directed steps with a response scoreboard and a behavioural alu.
// Follows ALU_ARB_ILLEGAL_OP_EN so both builds check the matching behaviour.
module tb_alu_request_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*3-1:0] req_op = '0;
    logic [N*8-1:0] req_a = '0;
    logic [N*8-1:0] req_b = '0;
    logic [N-1:0]   resp_valid;
    logic [N-1:0]   resp_ready = '1;
    logic [7:0]     resp_data;
    logic           resp_err;
    logic           alu_en;
    logic [2:0]     alu_op;
    logic [7:0]     alu_in1;
    logic [7:0]     alu_in2;
    logic [7:0]     alu_res = '0;
    logic           busy;

    logic [N-1:0]   v3 = '0;
    logic [N-1:0]   rdy3;
    logic [N*3-1:0] op3 = '0;
    logic [N*8-1:0] a3 = '0;
    logic [N*8-1:0] b3 = '0;
    logic [N-1:0]   rv3;
    logic [N-1:0]   rr3 = '1;
    logic [7:0]     rd3;
    logic           re3;
    logic           en3;
    logic [2:0]     aop3;
    logic [7:0]     ai1_3;
    logic [7:0]     ai2_3;
    logic [7:0]     s1 = '0;
    logic [7:0]     s2 = '0;
    logic [7:0]     s3 = '0;
    logic           busy3;

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] owner;
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    alu_request_arbiter dut (
        .clock_in(clk), .reset_in(rst_n),
        .req_valid_in(req_valid), .req_ready_out(req_ready),
        .req_opcode_in(req_op), .req_input1_in(req_a), .req_input2_in(req_b),
        .resp_valid_out(resp_valid), .resp_ready_in(resp_ready),
        .resp_data_out(resp_data), .resp_error_out(resp_err),
        .alu_enable_out(alu_en), .alu_opcode_out(alu_op),
        .alu_input1_out(alu_in1), .alu_input2_out(alu_in2),
        .alu_result_in(alu_res), .busy_out(busy)
    );

    alu_request_arbiter #(.ALU_LATENCY(3)) dut3 (
        .clock_in(clk), .reset_in(rst_n),
        .req_valid_in(v3), .req_ready_out(rdy3),
        .req_opcode_in(op3), .req_input1_in(a3), .req_input2_in(b3),
        .resp_valid_out(rv3), .resp_ready_in(rr3),
        .resp_data_out(rd3), .resp_error_out(re3),
        .alu_enable_out(en3), .alu_opcode_out(aop3),
        .alu_input1_out(ai1_3), .alu_input2_out(ai2_3),
        .alu_result_in(s3), .busy_out(busy3)
    );

    function automatic logic [7:0] alu_f(input logic [2:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
        logic signed [7:0] sa;
        logic signed [7:0] sbv;
        sa  = a;
        sbv = b;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a * b;
            3'd3: return (b == 8'd0) ? 8'd0 : sa / sbv;
            default: return 8'd0;
        endcase
    endfunction

    // Registered alu with one stage for dut and three stages for dut3.
    always @(posedge clk) begin
        if (alu_en)
            alu_res <= alu_f(alu_op, alu_in1, alu_in2);
        if (en3)
            s1 <= alu_f(aop3, ai1_3, ai2_3);
        s2 <= s1;
        s3 <= s2;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (resp_valid & resp_ready) != '0) begin
            if (sb.size() == 0) begin
                check("resp_unexpected", 32'(resp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("resp_owner", 32'(resp_valid), 32'(e.owner));
                check("resp_data", 32'(resp_data), 32'(e.data));
                check("resp_error", 32'(resp_err), 32'(e.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic set_req(input int k, input logic [2:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        req_op[k*3 +: 3] = op;
        req_a[k*8 +: 8]  = a;
        req_b[k*8 +: 8]  = b;
        req_valid[k]     = 1'b1;
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic er);
        exp_t x;
        x.owner = 4'(1 << k);
        x.data  = d;
        x.err   = er;
        sb.push_back(x);
    endtask

    task automatic serve(input int k);
        int c;
        c = 0;
        #1;
        while (!req_ready[k] && c < 50) begin
            tick();
            c++;
        end
        check($sformatf("grant_req%0d", k), 32'(req_ready[k]), 32'd1);
        tick();
        req_valid[k] = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (sb.size() != 0 && c < 50) begin
            tick();
            c++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        tick();
    endtask

    initial begin
        repeat (2) tick();
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu_en", 32'(alu_en), 32'd0);
        check("rst_data", 32'(resp_data), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single op, latency check.
        set_req(0, 3'd0, 8'd5, 8'd3);
        push(0, 8'd8, 1'b0);
        #1;
        check("t1_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid[0] = 1'b0;
        check("t1_issue_en", 32'(alu_en), 32'd1);
        check("t1_issue_op", 32'(alu_op), 32'd0);
        check("t1_issue_in1", 32'(alu_in1), 32'd5);
        check("t1_issue_in2", 32'(alu_in2), 32'd3);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_no_ready", 32'(req_ready), 32'd0);
        tick();
        check("t1_wait_en", 32'(alu_en), 32'd1);
        check("t1_wait_valid", 32'(resp_valid), 32'd0);
        tick();
        check("t1_resp_valid", 32'(resp_valid), 32'h1);
        check("t1_resp_data", 32'(resp_data), 32'd8);
        check("t1_resp_en", 32'(alu_en), 32'd0);
        check("t1_resp_in1", 32'(alu_in1), 32'd0);
        tick();
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_sb", 32'(sb.size()), 32'd0);

        // All requesters busy: round-robin order 0,1,2,3,0.
        do_reset();
        for (int k = 0; k < N; k++)
            set_req(k, 3'd2, 8'd2, 8'd3);
        for (int i = 0; i < 5; i++)
            push(i % 4, 8'd6, 1'b0);
        #1;
        for (int i = 0; i < 5; i++) begin
            int c;
            c = 0;
            while (req_ready == '0 && c < 20) begin
                tick();
                c++;
            end
            check($sformatf("t2_grant%0d", i), 32'(req_ready), 32'(1 << (i % 4)));
            tick();
        end
        req_valid = '0;
        drain();

        // Response back-pressure; non-owner ready is ignored.
        resp_ready = 4'b1101;
        set_req(1, 3'd1, 8'd2, 8'd7);
        set_req(0, 3'd0, 8'd1, 8'd1);
        push(1, 8'hFB, 1'b0);
        push(0, 8'd2, 1'b0);
        #1;
        check("t3_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid[1] = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", 32'(resp_valid), 32'h2);
            check("t3_hold_data", 32'(resp_data), 32'hFB);
            check("t3_hold_ready", 32'(req_ready), 32'd0);
            tick();
        end
        resp_ready = '1;
        tick();
        check("t3_next_ready", 32'(req_ready), 32'h1);
        serve(0);
        drain();

        // Reset during WAIT discards the op and resets the pointer.
        set_req(1, 3'd0, 8'd1, 8'd2);
        serve(1);
        tick();
        set_req(3, 3'd0, 8'd4, 8'd4);
        rst_n = 1'b0;
        #1;
        check("t4_alu_en", 32'(alu_en), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_resp_valid", 32'(resp_valid), 32'd0);
        check("t4_ready", 32'(req_ready), 32'd0);
        check("t4_alu_in1", 32'(alu_in1), 32'd0);
        tick();
        rst_n = 1'b1;
        set_req(0, 3'd0, 8'd3, 8'd3);
        #1;
        check("t4_grant0", 32'(req_ready), 32'h1);
        push(0, 8'd6, 1'b0);
        push(3, 8'd8, 1'b0);
        serve(0);
        serve(3);
        drain();

        // Opcode above 3'b100.
        set_req(2, 3'd7, 8'd9, 8'd9);
        #1;
        check("t5_ready", 32'(req_ready), 32'h4);
`ifdef ALU_ARB_ILLEGAL_OP_EN
        push(2, 8'd0, 1'b1);
        tick();
        req_valid[2] = 1'b0;
        check("t5_no_issue", 32'(alu_en), 32'd0);
        check("t5_resp_valid", 32'(resp_valid), 32'h4);
        check("t5_resp_data", 32'(resp_data), 32'd0);
        check("t5_resp_err", 32'(resp_err), 32'd1);
`else
        push(2, 8'd0, 1'b0);
        tick();
        req_valid[2] = 1'b0;
        check("t5_issue", 32'(alu_en), 32'd1);
        check("t5_op", 32'(alu_op), 32'd7);
        tick();
        tick();
        check("t5_resp_valid", 32'(resp_valid), 32'h4);
        check("t5_resp_err", 32'(resp_err), 32'd0);
`endif
        drain();

        // Three-cycle alu: response at handshake + 5.
        v3[0]     = 1'b1;
        op3[2:0]  = 3'd3;
        a3[7:0]   = 8'hFC;
        b3[7:0]   = 8'hFC;
        #1;
        check("t6_ready", 32'(rdy3), 32'h1);
        tick();
        v3[0] = 1'b0;
        for (int i = 1; i < 5; i++) begin
            check($sformatf("t6_quiet%0d", i), 32'(rv3), 32'd0);
            tick();
        end
        check("t6_resp_valid", 32'(rv3), 32'h1);
        check("t6_resp_data", 32'(rd3), 32'd1);
        tick();
        check("t6_idle", 32'(busy3), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
